// File: rtl/primes_sieve_hsimple.sv
// rtl/primes_sieve_hsimple.sv - sieve-of-Eratosthenes prime counter over a 256-bit HSIMPLE DRAM port
// Optional debug port outerv is enabled by defining OUTERV_PORT_EN.
module primes_sieve_hsimple #(
    parameter int LIMIT = 10000,
    parameter int DW    = 256,
    parameter int AW    = 22
) (
    input  logic              clk,
    input  logic              reset,
    output logic              hs_dram0bank_REQ,
    input  logic              hs_dram0bank_ACK,
    output logic              hs_dram0bank_RWBAR,
    output logic [AW-1:0]     hs_dram0bank_ADDR,
    output logic [DW-1:0]     hs_dram0bank_WDATA,
    output logic [DW/8-1:0]   hs_dram0bank_LANES,
    input  logic [DW-1:0]     hs_dram0bank_RDATA,
    output logic              done,
    output logic [31:0]       prime_count,
    output logic [4:0]        xpc10
`ifdef OUTERV_PORT_EN
    ,
    output logic [63:0]       outerv
`endif
);

    localparam int              LANES_N = DW / 8;
    localparam int              NW      = (LIMIT + 31) / 32;
    localparam logic [31:0]     LIM32   = 32'(LIMIT);
    localparam logic [AW-1:0]   LAST_W  = AW'(NW - 1);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_P_INIT = 3'd1,
        S_P_READ = 3'd2,
        S_MARK   = 3'd3,
        S_P_NEXT = 3'd4,
        S_COUNT  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         p;
    logic [31:0]         m;
    logic [AW-1:0]       widx;
    logic [31:0]         count;

    logic                xfer;
    logic                idle;
    logic [7:0]          flag_byte;
    logic [31:0]         p_inc;
    logic [63:0]         p_inc_sq;
    logic [5:0]          word_count;

    logic                issue;
    logic                issue_rd;
    logic [AW-1:0]       issue_addr;
    logic [DW-1:0]       issue_wdata;
    logic [LANES_N-1:0]  issue_lanes;

    // A new access may only start once ACK has been seen low with no request outstanding.
    assign xfer      = hs_dram0bank_REQ & hs_dram0bank_ACK;
    assign idle      = ~hs_dram0bank_REQ & ~hs_dram0bank_ACK;
    assign flag_byte = hs_dram0bank_RDATA[{p[4:0], 3'b000} +: 8];
    assign p_inc     = p + 32'd1;
    assign p_inc_sq  = {32'd0, p_inc} * {32'd0, p_inc};

    assign prime_count = count;
`ifdef OUTERV_PORT_EN
    assign outerv = {count, p};
`endif

    always_comb begin
        word_count = '0;
        for (int k = 0; k < LANES_N; k++) begin
            if ((hs_dram0bank_RDATA[8*k +: 8] != 8'd0) &&
                (32'({widx, 5'(k)}) >= 32'd2) &&
                (32'({widx, 5'(k)}) < LIM32)) begin
                word_count = word_count + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR:  if (xfer && widx == LAST_W) state_nxt = S_P_INIT;
            S_P_INIT: state_nxt = S_P_READ;
            S_P_READ: if (xfer) state_nxt = (flag_byte != 8'd0) ? S_MARK : S_P_NEXT;
            S_MARK:   if (m >= LIM32) state_nxt = S_P_NEXT;
            S_P_NEXT: state_nxt = (p_inc_sq < 64'(LIMIT)) ? S_P_READ : S_COUNT;
            S_COUNT:  if (xfer && widx == LAST_W) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        issue_rd    = 1'b1;
        issue_addr  = '0;
        issue_wdata = '0;
        issue_lanes = '0;
        done        = (state == S_DONE);
        xpc10       = {2'b00, state};
        case (state)
            S_CLEAR: begin
                issue       = idle;
                issue_rd    = 1'b0;
                issue_addr  = widx;
                issue_wdata = {LANES_N{8'h01}};
                issue_lanes = '1;
            end
            S_P_READ: begin
                issue      = idle;
                issue_addr = p[AW+4:5];
            end
            S_MARK: begin
                issue       = idle && (m < LIM32);
                issue_rd    = 1'b0;
                issue_addr  = m[AW+4:5];
                issue_lanes = {{(LANES_N-1){1'b0}}, 1'b1} << m[4:0];
            end
            S_COUNT: begin
                issue      = idle;
                issue_addr = widx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_dram0bank_REQ   <= 1'b0;
            hs_dram0bank_RWBAR <= 1'b1;
            hs_dram0bank_ADDR  <= '0;
            hs_dram0bank_WDATA <= '0;
            hs_dram0bank_LANES <= '0;
            p                  <= '0;
            m                  <= '0;
            widx               <= '0;
            count              <= '0;
        end else begin
            if (xfer) begin
                hs_dram0bank_REQ <= 1'b0;
            end else if (issue) begin
                hs_dram0bank_REQ   <= 1'b1;
                hs_dram0bank_RWBAR <= issue_rd;
                hs_dram0bank_ADDR  <= issue_addr;
                hs_dram0bank_WDATA <= issue_wdata;
                hs_dram0bank_LANES <= issue_lanes;
            end
            case (state)
                S_CLEAR:  if (xfer) widx <= (widx == LAST_W) ? '0 : widx + 1'b1;
                S_P_INIT: p <= 32'd2;
                S_P_READ: if (xfer && flag_byte != 8'd0) m <= p * p;
                S_MARK:   if (xfer) m <= m + p;
                S_P_NEXT: begin
                    p <= p_inc;
                    if (!(p_inc_sq < 64'(LIMIT))) begin
                        widx  <= '0;
                        count <= '0;
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        count <= count + 32'(word_count);
                        widx  <= widx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_primes_sieve_hsimple.sv
// tb/tb_primes_sieve_hsimple.sv - parallel sieve instances against behavioural HSIMPLE memory banks
module tb_primes_sieve_hsimple;

    localparam int N = 5;

    function automatic int lim_of(input int g);
        case (g)
            0:       return 100;
            1:       return 10000;
            2:       return 32;
            default: return 100;
        endcase
    endfunction

    function automatic int dly_of(input int g);
        return (g == 3) ? 5 : 1;
    endfunction

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int count_primes(input int lim);
        int c;
        c = 0;
        for (int n = 2; n < lim; n++) begin
            if (is_prime(n)) c++;
        end
        return c;
    endfunction

    logic         clk = 1'b0;
    logic [N-1:0] rst_v = '1;
    int           errors = 0;
    int           checks = 0;
    int           exp_q[$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_inst
        logic         req;
        logic         ack = 1'b0;
        logic         rw;
        logic [21:0]  addr;
        logic [255:0] wd;
        logic [31:0]  ln;
        logic [255:0] rd = '0;
        logic         done;
        logic [31:0]  pc;
        logic [4:0]   xpc;
`ifdef OUTERV_PORT_EN
        logic [63:0]  ov;
`endif
        logic [255:0] mem [320];
        int           cnt = 0;
        int           fullw = 0;
        int           viol = 0;
        logic         pr = 1'b0;
        logic         pa = 1'b0;
        logic         prst = 1'b1;
        logic         prw = 1'b1;
        logic [21:0]  paddr = '0;
        logic [255:0] pwd = '0;
        logic [31:0]  pln = '0;

        primes_sieve_hsimple #(.LIMIT(lim_of(g))) u_dut (
            .clk                (clk),
            .reset              (rst_v[g]),
            .hs_dram0bank_REQ   (req),
            .hs_dram0bank_ACK   (ack),
            .hs_dram0bank_RWBAR (rw),
            .hs_dram0bank_ADDR  (addr),
            .hs_dram0bank_WDATA (wd),
            .hs_dram0bank_LANES (ln),
            .hs_dram0bank_RDATA (rd),
            .done               (done),
            .prime_count        (pc),
            .xpc10              (xpc)
`ifdef OUTERV_PORT_EN
            ,
            .outerv             (ov)
`endif
        );

        // Memory bank: acknowledges dly_of(g) cycles after seeing a request, ACK is a one-cycle pulse.
        always @(posedge clk) begin
            if (ack) begin
                ack <= 1'b0;
            end else if (req) begin
                if (cnt >= dly_of(g) - 1) begin
                    cnt <= 0;
                    ack <= 1'b1;
                    if (rw) begin
                        rd <= mem[addr];
                    end else begin
                        for (int k = 0; k < 32; k++) begin
                            if (ln[k]) mem[addr][8*k +: 8] <= wd[8*k +: 8];
                        end
                        if (&ln) fullw <= fullw + 1;
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end

        always @(posedge clk) begin
            if (!rst_v[g] && !prst) begin
                viol <= viol
                    + int'(pr && !pa && !(req && addr == paddr && rw == prw && wd == pwd && ln == pln))
                    + int'(req && !pr && ack)
                    + int'(pr && pa && req)
                    + int'(req && rw && ln != 32'd0);
            end
            pr    <= req;
            pa    <= ack;
            prst  <= rst_v[g];
            prw   <= rw;
            paddr <= addr;
            pwd   <= wd;
            pln   <= ln;
        end
    end

    initial begin
        int           cyc;
        int           got [N];
        logic [255:0] ew;
        logic [31:0]  pc_hold;

        rst_v = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",   256'(g_inst[0].req),  256'(0));
        check("rst_rwbar", 256'(g_inst[0].rw),   256'(1));
        check("rst_addr",  256'(g_inst[0].addr), 256'(0));
        check("rst_wdata", g_inst[0].wd,         256'(0));
        check("rst_lanes", 256'(g_inst[0].ln),   256'(0));
        check("rst_done",  256'(g_inst[0].done), 256'(0));
        check("rst_count", 256'(g_inst[0].pc),   256'(0));
        check("rst_state", 256'(g_inst[0].xpc),  256'(0));
`ifdef OUTERV_PORT_EN
        check("rst_outerv", 256'(g_inst[0].ov),  256'(0));
`endif

        for (int i = 0; i < N; i++) exp_q.push_back(count_primes(lim_of(i)));
        @(negedge clk);
        rst_v = '0;

        cyc = 0;
        while (!(g_inst[4].xpc == 5'd3 && g_inst[4].req) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("mark_reached", 256'(cyc < 5000), 256'(1));
        rst_v[4] = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req",   256'(g_inst[4].req),  256'(0));
        check("midrst_state", 256'(g_inst[4].xpc),  256'(0));
        check("midrst_done",  256'(g_inst[4].done), 256'(0));
        @(negedge clk);
        rst_v[4] = 1'b0;

        cyc = 0;
        while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done &&
                 g_inst[3].done && g_inst[4].done) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
        end
        check("all_done", 256'(cyc < 80000), 256'(1));

        got[0] = int'(g_inst[0].pc);
        got[1] = int'(g_inst[1].pc);
        got[2] = int'(g_inst[2].pc);
        got[3] = int'(g_inst[3].pc);
        got[4] = int'(g_inst[4].pc);
        for (int i = 0; i < N; i++) begin
            int e;
            e = exp_q.pop_front();
            check($sformatf("prime_count[%0d]", i), 256'(got[i]), 256'(e));
        end

        check("clear_writes_l100", 256'(g_inst[0].fullw), 256'(4));
        check("clear_writes_l32",  256'(g_inst[2].fullw), 256'(1));
        ew = '0;
        for (int i = 0; i < 32; i++) ew[8*i +: 8] = (i < 2 || is_prime(i)) ? 8'h01 : 8'h00;
        check("flags_l32", g_inst[2].mem[0], ew);

        check("proto0", 256'(g_inst[0].viol), 256'(0));
        check("proto1", 256'(g_inst[1].viol), 256'(0));
        check("proto2", 256'(g_inst[2].viol), 256'(0));
        check("proto3", 256'(g_inst[3].viol), 256'(0));
        check("proto4", 256'(g_inst[4].viol), 256'(0));

`ifdef OUTERV_PORT_EN
        check("outerv_hi", 256'(g_inst[0].ov[63:32]), 256'(count_primes(100)));
`endif

        pc_hold = g_inst[0].pc;
        repeat (10) @(negedge clk);
        check("hold_count", 256'(g_inst[0].pc),   256'(pc_hold));
        check("hold_done",  256'(g_inst[0].done), 256'(1));
        check("hold_req",   256'(g_inst[0].req),  256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
